// File: rtl/rf_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// FSM states, the default read timeout and the requester indices.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_t;

  localparam int   DEF_RD_TIMEOUT = 15;
  localparam logic REQ0_IDX       = 1'b0;
  localparam logic REQ1_IDX       = 1'b1;

endpackage

// File: rtl/rf_arb_rr_pick.sv
// Combinational 2-way round-robin picker: on contention the requester that
// was not granted last wins; otherwise the single valid requester wins.
module rf_arb_rr_pick
  import rf_arb_pkg::*;
(
  input  logic i_vld0,
  input  logic i_vld1,
  input  logic i_last,
  output logic o_winner,
  output logic o_any
);

  // Winner selection with last-grant tie break
  always_comb begin
    o_any = i_vld0 | i_vld1;
    if (i_vld0 && i_vld1) begin
      o_winner = (i_last == REQ0_IDX) ? REQ1_IDX : REQ0_IDX;
    end else if (i_vld1) begin
      o_winner = REQ1_IDX;
    end else begin
      o_winner = REQ0_IDX;
    end
  end

endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two requesters onto one register-file port (IDLE/ACCESS/WAIT_RD),
// returning read data to the owner and aborting reads that never complete.
module rf_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VLD,
  input  logic                  REQ0_WR,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  output logic                  REQ0_GNT,
  output logic [DATA_WIDTH-1:0] REQ0_RDATA,
  output logic                  REQ0_RVLD,
  input  logic                  REQ1_VLD,
  input  logic                  REQ1_WR,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  output logic                  REQ1_GNT,
  output logic [DATA_WIDTH-1:0] REQ1_RDATA,
  output logic                  REQ1_RVLD,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  output logic                  BUSY,
  output logic                  RD_ERR
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  arb_state_t             r_state;
  logic                   r_last;
  logic                   r_owner;
  logic                   r_wr;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_winner;
  logic                   w_any;
  logic                   w_sel_wr;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;

  rf_arb_rr_pick u_pick (
    .i_vld0   (REQ0_VLD),
    .i_vld1   (REQ1_VLD),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Request fields of the current winner
  always_comb begin
    if (w_winner == REQ1_IDX) begin
      w_sel_wr    = REQ1_WR;
      w_sel_addr  = REQ1_ADDR;
      w_sel_wdata = REQ1_WDATA;
    end else begin
      w_sel_wr    = REQ0_WR;
      w_sel_addr  = REQ0_ADDR;
      w_sel_wdata = REQ0_WDATA;
    end
  end

  // Arbiter FSM; every output is registered here so strobes are glitch-free
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_last     <= REQ1_IDX;
      r_owner    <= REQ0_IDX;
      r_wr       <= 1'b0;
      r_cnt      <= '0;
      REQ0_GNT   <= 1'b0;
      REQ1_GNT   <= 1'b0;
      REQ0_RVLD  <= 1'b0;
      REQ1_RVLD  <= 1'b0;
      REQ0_RDATA <= '0;
      REQ1_RDATA <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      BUSY       <= 1'b0;
      RD_ERR     <= 1'b0;
    end else begin
      REQ0_GNT  <= 1'b0;
      REQ1_GNT  <= 1'b0;
      REQ0_RVLD <= 1'b0;
      REQ1_RVLD <= 1'b0;
      RF_WrEn   <= 1'b0;
      RF_RdEn   <= 1'b0;
      RD_ERR    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner    <= w_winner;
            r_last     <= w_winner;
            r_wr       <= w_sel_wr;
            RF_Address <= w_sel_addr;
            RF_WrData  <= w_sel_wdata;
            RF_WrEn    <= w_sel_wr;
            RF_RdEn    <= ~w_sel_wr;
            REQ0_GNT   <= (w_winner == REQ0_IDX);
            REQ1_GNT   <= (w_winner == REQ1_IDX);
            BUSY       <= 1'b1;
            r_state    <= ST_ACCESS;
          end else begin
            BUSY <= 1'b0;
          end
        end
        ST_ACCESS: begin
          RF_Address <= '0;
          RF_WrData  <= '0;
          r_cnt      <= '0;
          if (r_wr) begin
            BUSY    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            BUSY    <= 1'b1;
            r_state <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          // A timed-out read still answers its owner, with zero data
          if (RF_RdData_VLD) begin
            if (r_owner == REQ1_IDX) begin
              REQ1_RDATA <= RF_RdData;
              REQ1_RVLD  <= 1'b1;
            end else begin
              REQ0_RDATA <= RF_RdData;
              REQ0_RVLD  <= 1'b1;
            end
            BUSY    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            if (r_owner == REQ1_IDX) begin
              REQ1_RDATA <= '0;
              REQ1_RVLD  <= 1'b1;
            end else begin
              REQ0_RDATA <= '0;
              REQ0_RVLD  <= 1'b1;
            end
            RD_ERR  <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          BUSY    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
